// File: rtl/pipe_stall_ctrl_if.sv
// Enable/flush bus between the stall controller (master) and the pipeline's
// enabled registers PC, IF/ID, ID/EX, EX/MEM, MEM/WB (slave).
interface pipe_stall_ctrl_if;
   logic pc_en;
   logic ifid_en;
   logic idex_en;
   logic exmem_en;
   logic memwb_en;
   logic ifid_flush;
   logic idex_flush;
   logic exmem_flush;

   modport master (
      output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
      output ifid_flush, idex_flush, exmem_flush
   );

   modport slave (
      input pc_en, ifid_en, idex_en, exmem_en, memwb_en,
      input ifid_flush, idex_flush, exmem_flush
   );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// LEGv8 5-stage hazard/stall controller: Mealy enables/flushes plus memory-wait FSM.
// Optional stall statistics counter enabled by defining STALL_CNT_EN.
module pipe_stall_ctrl #(
   parameter int REG_W    = 5,
   parameter int MAX_WAIT = 15,
   parameter int CNT_W    = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [REG_W-1:0]   id_rn,
   input  logic [REG_W-1:0]   id_rm,
   input  logic               ex_memread,
   input  logic [REG_W-1:0]   ex_rd,
   input  logic               mem_branch_taken,
   input  logic               dmem_req,
   input  logic               dmem_ack,
   pipe_stall_ctrl_if.master  pipe,
   output logic               mem_timeout,
   output logic [CNT_W-1:0]   stall_cycles
);

   localparam int WC_W = $clog2(MAX_WAIT) + 1;
   localparam logic [WC_W-1:0]  WAIT_LAST = WC_W'(MAX_WAIT - 1);
   localparam logic [REG_W-1:0] XZR       = REG_W'(31);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      MEMWAIT = 2'd1,
      RELEASE = 2'd2
   } state_t;

   state_t          state, state_nx;
   logic [WC_W-1:0] wait_cnt, wait_nx;
   logic            timeout_set;
   logic            mem_stall;
   logic            load_use;
   logic [4:0]      en_c;   // {pc, ifid, idex, exmem, memwb}
   logic [2:0]      fl_c;   // {ifid, idex, exmem}

   assign mem_stall = dmem_req & ~dmem_ack;
   assign load_use  = ex_memread && (ex_rd != XZR) &&
                      ((ex_rd == id_rn) || (ex_rd == id_rm));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= RUN;
         wait_cnt    <= '0;
         mem_timeout <= 1'b0;
      end else begin
         state    <= state_nx;
         wait_cnt <= wait_nx;
         if (timeout_set) mem_timeout <= 1'b1;
      end
   end

   always_comb begin
      state_nx    = state;
      wait_nx     = wait_cnt;
      timeout_set = 1'b0;
      en_c        = 5'b00000;
      fl_c        = 3'b000;
      case (state)
         RUN, MEMWAIT: begin
            if (mem_stall) begin
               if (state == RUN) begin
                  state_nx = MEMWAIT;
                  wait_nx  = WC_W'(1);
               end else begin
                  // The stalled cycle that brings the count to MAX_WAIT is the last one.
                  wait_nx = wait_cnt + WC_W'(1);
                  if (wait_cnt == WAIT_LAST) begin
                     timeout_set = 1'b1;
                     state_nx    = RELEASE;
                  end
               end
            end else begin
               state_nx = RUN;
               wait_nx  = '0;
               if (mem_branch_taken) begin
                  en_c = 5'b11111;
                  fl_c = 3'b111;
               end else if (load_use) begin
                  en_c = 5'b00111;
                  fl_c = 3'b010;
               end else begin
                  en_c = 5'b11111;
               end
            end
         end
         RELEASE: begin
            state_nx = RUN;
            wait_nx  = '0;
            en_c     = 5'b11111;
            if (mem_branch_taken) fl_c = 3'b111;
         end
         default: begin
            state_nx = RUN;
            wait_nx  = '0;
         end
      endcase
      if (!reset) begin
         en_c = 5'b00000;
         fl_c = 3'b000;
      end
   end

   assign pipe.pc_en       = en_c[4];
   assign pipe.ifid_en     = en_c[3];
   assign pipe.idex_en     = en_c[2];
   assign pipe.exmem_en    = en_c[1];
   assign pipe.memwb_en    = en_c[0];
   assign pipe.ifid_flush  = fl_c[2];
   assign pipe.idex_flush  = fl_c[1];
   assign pipe.exmem_flush = fl_c[0];

`ifdef STALL_CNT_EN
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   logic [CNT_W-1:0] stall_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)        stall_q <= '0;
      else if (!en_c[4]) stall_q <= sat_inc(stall_q);
   end

   assign stall_cycles = stall_q;
`else
   assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed self-checking bench for pipe_stall_ctrl (MAX_WAIT=15); counter
// expectations follow STALL_CNT_EN.
module tb_pipe_stall_ctrl;
   localparam int MW = 15;

   localparam logic [7:0] ZERO    = 8'b00000_000;
   localparam logic [7:0] ALL_RUN = 8'b11111_000;
   localparam logic [7:0] FROZEN  = 8'b00000_000;
   localparam logic [7:0] BRANCH  = 8'b11111_111;
   localparam logic [7:0] LOADUSE = 8'b00111_010;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  id_rn, id_rm, ex_rd;
   logic        ex_memread, mem_branch_taken, dmem_req, dmem_ack;
   logic        mem_timeout;
   logic [31:0] stall_cycles;
   logic [7:0]  outs;
   int          n_chk = 0;
   int          n_pass = 0;

   pipe_stall_ctrl_if bus ();

   pipe_stall_ctrl #(.REG_W(5), .MAX_WAIT(MW), .CNT_W(32)) dut (
      .clk(clk), .reset(reset),
      .id_rn(id_rn), .id_rm(id_rm),
      .ex_memread(ex_memread), .ex_rd(ex_rd),
      .mem_branch_taken(mem_branch_taken),
      .dmem_req(dmem_req), .dmem_ack(dmem_ack),
      .pipe(bus.master),
      .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   assign outs = {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
                  bus.ifid_flush, bus.idex_flush, bus.exmem_flush};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [31:0] ec(input int v);
`ifdef STALL_CNT_EN
      return 32'(v);
`else
      return 32'(v * 0);
`endif
   endfunction

   task automatic set_in(input logic [4:0] rn, input logic [4:0] rm, input logic memrd,
                         input logic [4:0] rd, input logic br, input logic req, input logic ack);
      id_rn = rn; id_rm = rm; ex_memread = memrd; ex_rd = rd;
      mem_branch_taken = br; dmem_req = req; dmem_ack = ack;
   endtask

   // Inputs are applied just after a negedge; outputs checked 1 ns later, then
   // the cycle closes on the following posedge and we return at the next negedge.
   task automatic step(input string tag, input logic [7:0] exp);
      #1;
      chk(tag, 32'(outs), 32'(exp));
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b0;
      set_in(5'd3, 5'd3, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      step("reset_outs", ZERO);
      chk("reset_timeout", 32'(mem_timeout), 32'd0);
      chk("reset_cnt", stall_cycles, 32'd0);

      reset = 1'b1;
      set_in(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      step("idle", ALL_RUN);

      set_in(5'd1, 5'd3, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0);
      step("loaduse_rm", LOADUSE);
      chk("cnt_after_lu", stall_cycles, ec(1));
      set_in(5'd31, 5'd4, 1'b1, 5'd31, 1'b0, 1'b0, 1'b0);
      step("xzr_no_stall", ALL_RUN);
      set_in(5'd5, 5'd6, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
      step("loaduse_rn", LOADUSE);
      set_in(5'd5, 5'd6, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0);
      step("no_memread", ALL_RUN);

      set_in(5'd5, 5'd6, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
      step("branch_over_lu", BRANCH);
      set_in(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      step("after_branch", ALL_RUN);

      set_in(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
      step("zero_wait", ALL_RUN);
      chk("cnt_zero_wait", stall_cycles, ec(2));

      set_in(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) step("memwait_frozen", FROZEN);
      set_in(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
      step("memwait_ack", ALL_RUN);
      chk("cnt_memwait", stall_cycles, ec(5));
      set_in(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      step("memwait_back_run", ALL_RUN);
      chk("no_timeout_yet", 32'(mem_timeout), 32'd0);

      set_in(5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 2; i++) step("stall_br_frozen", FROZEN);
      set_in(5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
      step("stall_br_flush", BRANCH);
      set_in(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      step("stall_br_after", ALL_RUN);
      chk("cnt_stall_br", stall_cycles, ec(7));

      set_in(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < MW; i++) begin
         chk("tmo_flag_low", 32'(mem_timeout), 32'd0);
         step("tmo_frozen", FROZEN);
      end
      chk("tmo_flag_set", 32'(mem_timeout), 32'd1);
      set_in(5'd3, 5'd2, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0);
      step("tmo_release", ALL_RUN);
      set_in(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      step("tmo_restall", FROZEN);
      set_in(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      step("tmo_req_drop", ALL_RUN);
      chk("tmo_sticky", 32'(mem_timeout), 32'd1);
      chk("cnt_tmo", stall_cycles, ec(23));

      set_in(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      step("rmw_frozen", FROZEN);
      chk("cnt_before_rst", stall_cycles, ec(24));
      reset = 1'b0;
      step("rmw_reset_outs", ZERO);
      chk("rmw_timeout_clr", 32'(mem_timeout), 32'd0);
      chk("rmw_cnt_clr", stall_cycles, 32'd0);
      reset = 1'b1;
      set_in(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      step("rmw_run", ALL_RUN);
      set_in(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      step("rmw_new_stall", FROZEN);
      set_in(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
      step("rmw_new_ack", ALL_RUN);
      chk("rmw_timeout_low", 32'(mem_timeout), 32'd0);
      chk("rmw_cnt", stall_cycles, ec(1));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
